bus_ready_skid: RTL and testbench
=================================

# bus_ready_skid

Ready-path register slice for a valid/ready streaming bus, inserted between an upstream producer and a downstream consumer. It breaks the combinational ready path by driving `ready_o` from a flop, and uses a one-entry skid register so no beat is lost when downstream deasserts ready. The forward path is pass-through by default. An optional build mode also registers the forward path, giving a full two-entry register slice.

## Interface
- `Width`, default 32: data beat width in bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `valid_i`  in  1  upstream beat valid.
- `data_i`  in  Width  upstream beat data.
- `ready_o`  out  1  to upstream; registered (flop output, no combinational input path).
- `valid_o`  out  1  downstream beat valid.
- `data_o`  out  Width  downstream beat data.
- `ready_i`  in  1  downstream ready.

## Operation
- A beat transfers on a clock edge where valid and ready are both 1 on that side.
- Internal state:
  - `skid_valid`, `skid_data[Width-1:0]`.
  - `ready_o` flop; the value it holds is always `!skid_valid`.
- Default (pass-through) mode:
  - `valid_o = valid_i | skid_valid`.
  - `data_o = skid_valid ? skid_data : data_i`.
- Capture rule:
  - Condition: `!skid_valid && valid_i && !ready_i`.
  - Action: `skid_data <= data_i`, `skid_valid <= 1`, `ready_o <= 0`.
  - Meaning: upstream handshake completed, but downstream did not take the beat.
- Drain rule:
  - Condition: `skid_valid && ready_i`.
  - Action: skid beat is consumed; `skid_valid <= 0`, `ready_o <= 1`.
- While `skid_valid = 1`:
  - `ready_o = 0`, and `data_i` / `valid_i` are ignored.
  - Upstream must hold its beat until `ready_o` returns to 1.
- Ordering: beats leave in arrival order; no beat is dropped or duplicated.
- Capacity: exactly one buffered beat.
- Throughput: 1 beat/cycle while `ready_i` stays 1.

## Timing
- Reset (`rst = 1` at a rising edge):
  - `skid_valid <= 0`, `skid_data <= 0`, `ready_o <= 1`.
  - In default mode, `valid_o`/`data_o` follow `valid_i`/`data_i` combinationally, including during reset. Upstream must hold `valid_i = 0` while `rst = 1`.
- Reset asserted mid-operation: any skid beat is discarded; `ready_o` is 1 on the cycle after the reset edge.
- Latency, default mode: 0 cycles (combinational forward path).
- `ready_o` response:
  - Falls 1 cycle after the edge at which a stalled beat was captured.
  - Rises 1 cycle after the edge at which the skid beat drained.
- Capture and drain can never occur on the same edge, because capture requires `!skid_valid`.
- Downstream toggling `ready_i` every cycle: no loss, and sustained throughput is bounded by the `ready_i` duty.

## Configuration
- Macro `BUS_READY_DELAY_OUTREG_EN`.
- Undefined: pass-through forward path exactly as above.
- Defined: `valid_o` and `data_o` also come from an output register.
  - Reset values: `valid_o = 0`, `data_o = 0`.
  - Output register load condition: `!valid_o || ready_i`.
  - Source when loading: the skid beat if `skid_valid`, else the upstream beat when `valid_i && ready_o`. When neither source is present, `valid_o <= 0`.
  - An upstream beat accepted while the output register is full and `ready_i = 0` goes into the skid.
  - `ready_o` remains `!skid_valid`, registered.
  - Latency: 1 cycle. Capacity: 2 beats. Throughput: 1 beat/cycle.

## Test plan
- Reset: hold `rst = 1` for 3 cycles, `valid_i = 0` -> `ready_o = 1`, `valid_o = 0`; with the macro defined, also `data_o = 0`.
- Streaming: `ready_i = 1` constant, upstream sends 0x0 through 0xC back to back -> `data_o` shows 0x0 through 0xC in order, one per cycle, `ready_o` stays 1. Latency is 0 cycles, or 1 cycle with the macro.
- Single stall: send 0x5 with `ready_i = 0` for one cycle -> 0x5 captured in the skid, `ready_o = 0` the next cycle, `valid_o = 1` with `data_o = 0x5` held. When `ready_i = 1`, 0x5 transfers and `ready_o` returns to 1.
- Alternating ready: 6 cycles of `ready_i = 1`, then `ready_i` alternates 0/1 for 14 cycles while upstream offers 0x0 through 0xC, sending only when `ready_o || !valid_i` -> all 13 beats delivered exactly once, in order, with no beat presented while `ready_o = 0` accepted.
- Upstream hold: with the skid full, change `data_i` while `ready_o = 0` -> `data_o` is unchanged and the changed value is not accepted.
- Mid-stall reset: assert `rst` while `skid_valid = 1` -> skid cleared, `ready_o = 1` on the next cycle, and the stalled beat is never emitted.

Source files
------------

// File: rtl/bus_ready_skid_if.sv
// Valid/ready streaming bus seen by the ready-path register slice.
// The slave modport is the slice's view; master is the surrounding environment.
interface bus_ready_skid_if #(
  parameter int Width = 32
);
  logic             valid_i;
  logic [Width-1:0] data_i;
  logic             ready_o;
  logic             valid_o;
  logic [Width-1:0] data_o;
  logic             ready_i;

  modport slave (
    input  valid_i,
    input  data_i,
    output ready_o,
    output valid_o,
    output data_o,
    input  ready_i
  );

  modport master (
    output valid_i,
    output data_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    output ready_i
  );
endinterface

// File: rtl/bus_ready_skid.sv
// Ready-path register slice with a one-entry skid buffer; ready_o comes straight from a flop.
// Define BUS_READY_DELAY_OUTREG_EN to also register valid_o/data_o (two-entry full slice).
module bus_ready_skid #(
  parameter int Width = 32
) (
  input  logic              clk,
  input  logic              rst,
  bus_ready_skid_if.slave   bus
);

  logic             skid_valid_reg;
  logic [Width-1:0] skid_data_reg;
  logic             ready_reg;
  logic             capture;
  logic             drain;

`ifdef BUS_READY_DELAY_OUTREG_EN
  logic             out_valid_reg;
  logic [Width-1:0] out_data_reg;
  logic             out_load;
  logic             accept;

  assign out_load = !out_valid_reg || bus.ready_i;
  assign accept   = bus.valid_i && ready_reg;
  // An accepted beat only parks in the skid when the output register cannot take it.
  assign capture  = accept && !out_load;
  assign drain    = skid_valid_reg && out_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (out_load) begin
      if (skid_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= skid_data_reg;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= bus.data_i;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.valid_o = out_valid_reg;
  assign bus.data_o  = out_data_reg;
`else
  assign capture     = !skid_valid_reg && bus.valid_i && !bus.ready_i;
  assign drain       = skid_valid_reg && bus.ready_i;
  assign bus.valid_o = bus.valid_i | skid_valid_reg;
  assign bus.data_o  = skid_valid_reg ? skid_data_reg : bus.data_i;
`endif

  // ready_reg always mirrors !skid_valid_reg, but is its own flop so ready_o has no input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b1;
    end else if (capture) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= bus.data_i;
      ready_reg      <= 1'b0;
    end else if (drain) begin
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end
  end

  assign bus.ready_o = ready_reg;

endmodule

// File: tb/tb_bus_ready_skid.sv
// Randomized bench for bus_ready_skid against a queue model of in-flight beats.
// Build with BUS_READY_DELAY_OUTREG_EN defined to exercise the registered forward path.
module tb_bus_ready_skid;
  localparam int W = 32;
`ifdef BUS_READY_DELAY_OUTREG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_ready_skid_if #(.Width(W)) bus ();

  bus_ready_skid #(.Width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [W-1:0] q[$];
  logic         s_ready, s_valid;
  logic [W-1:0] s_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the in-flight queue, then account transfers.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                       input logic rdy, output logic acc);
    int occ;
    logic exp_valid;
    logic del;
    @(negedge clk);
    rst = r; bus.valid_i = v; bus.data_i = d; bus.ready_i = rdy;
    #1;
    s_ready = bus.ready_o; s_valid = bus.valid_o; s_data = bus.data_o;
    acc = 1'b0; del = 1'b0;
    if (!r) begin
      occ = q.size();
      check_val("ready", 64'(s_ready), 64'(occ < CAP));
`ifdef BUS_READY_DELAY_OUTREG_EN
      exp_valid = (occ > 0);
`else
      exp_valid = v || (occ > 0);
`endif
      check_val("valid", 64'(s_valid), 64'(exp_valid));
      if (s_valid && exp_valid)
        check_val("data", 64'(s_data), 64'((occ > 0) ? q[0] : d));
      acc = v && s_ready;
      del = s_valid && rdy;
      $display("cyc v=%0d d=%0h rdy=%0d | ready_o=%0d valid_o=%0d data_o=%0h occ=%0d",
               v, d, rdy, s_ready, s_valid, s_data, occ);
    end
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (acc) q.push_back(d);
      if (del) begin
        if (q.size() == 0) check_val("spurious_beat", 64'(s_data), 64'hDEAD);
        else void'(q.pop_front());
        delivered++;
      end
    end
  endtask

  task automatic drain_all(input string tag);
    logic acc;
    for (int k = 0; k < 10 && q.size() > 0; k++) cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check_val(tag, 64'(q.size()), 64'd0);
  endtask

  // mode 0: ready_i held high; mode 1: 6 cycles high then alternating 0/1.
  task automatic send_seq(input int n, input int mode);
    int idx = 0;
    int cyc = 0;
    int d0 = delivered;
    logic acc, rdy;
    while (idx < n && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc < 6) ? 1'b1 : logic'((cyc - 6) % 2));
      cycle(1'b0, 1'b1, W'(idx), rdy, acc);
      if (acc) idx++;
      cyc++;
    end
    check_val("send_done", 64'(idx), 64'(n));
    if (mode == 0) check_val("stream_rate", 64'(cyc), 64'(n));
    drain_all("seq_drained");
    check_val("seq_delivered", 64'(delivered - d0), 64'(n));
  endtask

  // Offer beats with ready_i low until the slice deasserts ready_o.
  task automatic fill(input logic [W-1:0] base);
    logic acc;
    logic [W-1:0] d = base;
    logic full = 1'b0;
    for (int k = 0; k < 6 && !full; k++) begin
      cycle(1'b0, 1'b1, d, 1'b0, acc);
      if (acc) d = d + 1;
      #1;
      full = !bus.ready_o;
    end
    check_val("fill_full", 64'(full), 64'd1);
  endtask

  initial begin
    logic acc;
    logic have;
    logic [W-1:0] rd;
    logic [W-1:0] hold_exp;
    bus.valid_i = 1'b0; bus.data_i = '0; bus.ready_i = 1'b1;

    // Reset for 3 cycles
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0, 1'b1, acc);
    @(negedge clk); rst = 1'b0; #1;
    check_val("rst_ready", 64'(bus.ready_o), 64'd1);
    check_val("rst_valid", 64'(bus.valid_o), 64'd0);
`ifdef BUS_READY_DELAY_OUTREG_EN
    check_val("rst_data", 64'(bus.data_o), 64'd0);
`endif

    send_seq(13, 0);

    // Single stall of 0x5
    cycle(1'b0, 1'b1, W'(5), 1'b0, acc);
    check_val("stall_acc", 64'(acc), 64'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, acc);
`ifndef BUS_READY_DELAY_OUTREG_EN
    check_val("stall_ready", 64'(s_ready), 64'd0);
`endif
    check_val("stall_data", 64'(s_data), 64'h5);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check_val("stall_out", 64'(s_data), 64'h5);
    #1;
    check_val("stall_ready_back", 64'(bus.ready_o), 64'd1);
    drain_all("stall_drained");

    send_seq(13, 1);

    // Upstream changes data while stalled; the changed value is only taken once ready returns
    fill(W'(32'h100));
    hold_exp = q[0];
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, W'(32'hBEEF + k), 1'b0, acc);
      check_val("hold_acc", 64'(acc), 64'd0);
      check_val("hold_data", 64'(s_data), 64'(hold_exp));
    end
    acc = 1'b0;
    for (int k = 0; k < 6 && !acc; k++) cycle(1'b0, 1'b1, W'(32'hBEF0), 1'b1, acc);
    check_val("hold_release", 64'(acc), 64'd1);
    drain_all("hold_drained");

    // Reset while the skid holds a beat; that beat must never appear
    fill(W'(32'h200));
    cycle(1'b1, 1'b0, '0, 1'b0, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    check_val("midrst_ready", 64'(s_ready), 64'd1);
    check_val("midrst_valid", 64'(s_valid), 64'd0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, '0, 1'b1, acc);

    // Random traffic
    have = 1'b0; rd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!have) begin
        have = ($urandom_range(0, 1) == 1);
        rd = $urandom;
      end
      cycle(1'b0, have, rd, ($urandom_range(0, 3) != 0), acc);
      if (acc) have = 1'b0;
    end
    drain_all("rand_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
